mem_bist: RTL and testbench

Built-in self-test initiator for the single-port `memory` block. On a start request it drives the memory's write-enable, address and write-data ports through a four-phase march: write pattern, read/verify, write inverse, read/verify. It then reports pass/fail and the first failing address. It sits between a host controller and a `memory` instance, replacing the normal initiator while test is running.

---
 rtl/mem_bist_pkg.sv | 31 +++
 rtl/mem_bist_if.sv | 32 +++
 rtl/mem_bist.sv | 125 ++++++++++++
 tb/tb_mem_bist.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and the expected-word helper for the memory march self-test.
// Latency: none, types and a pure function only.
// Backpressure: not applicable.
package bist_pkg;

   // Widest word and address the helper handles; callers slice the low bits.
   localparam int BIST_MAX_W = 64;
   localparam int BIST_MAX_A = 32;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_WRI  = 3'd3,
      S_RDI  = 3'd4,
      S_DONE = 3'd5
   } bist_state_t;

   // Address zero-extended (or truncated by the caller's slice) XOR pattern,
   // optionally inverted for the second half of the march.
   function automatic logic [BIST_MAX_W-1:0] bist_exp(
      input logic [BIST_MAX_A-1:0] addr,
      input logic [BIST_MAX_W-1:0] pat,
      input logic                  inv
   );
      logic [BIST_MAX_W-1:0] w_word;
      w_word = {{(BIST_MAX_W-BIST_MAX_A){1'b0}}, addr} ^ pat;
      return inv ? ~w_word : w_word;
   endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Bundle of host-control and memory-side signals for the march self-test.
// Latency: wires only.
// Backpressure: none; start is a request sampled when the engine is idle.
interface mem_bist_if #(
   parameter int WIDTH  = 8,
   parameter int LENGTH = 256
);
   localparam int ADDR_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1;

   logic                  start;
   logic [WIDTH-1:0]      pattern;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic [ADDR_WIDTH-1:0] fail_addr;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic [WIDTH-1:0]      mem_wd;
   logic [WIDTH-1:0]      mem_rd;

   // Host controller plus attached memory drive this side.
   modport master (
      output start, pattern, mem_rd,
      input  busy, done, pass, fail_addr, mem_we, mem_a, mem_wd
   );

   // The self-test engine.
   modport slave (
      input  start, pattern, mem_rd,
      output busy, done, pass, fail_addr, mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/mem_bist.sv
// Four-phase march self-test (write, verify, write inverse, verify) over LENGTH words.
// Latency: 4*LENGTH busy cycles on pass; aborts on the first read mismatch.
// Backpressure: start ignored while busy; memory is assumed always ready.
module mem_bist
   import bist_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int LENGTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   mem_bist_if.slave   bus
);
   localparam int ADDR_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);

   bist_state_t           r_state,     w_state;
   logic [ADDR_WIDTH-1:0] r_cnt,       w_cnt;
   logic [WIDTH-1:0]      r_pat,       w_pat;
   logic                  r_done,      w_done;
   logic                  r_pass,      w_pass;
   logic [ADDR_WIDTH-1:0] r_fail_addr, w_fail_addr;

   logic                  w_busy;
   logic                  w_wr_phase;
   logic                  w_rd_phase;
   logic                  w_inv;
   logic                  w_last;
   logic                  w_mis;
   logic [BIST_MAX_W-1:0] w_exp_full;
   logic [WIDTH-1:0]      w_exp;

   // Phase decode and expected word come only from registered state/counter.
   always_comb begin
      w_wr_phase = (r_state == S_WR) || (r_state == S_WRI);
      w_rd_phase = (r_state == S_RD) || (r_state == S_RDI);
      w_inv      = (r_state == S_WRI) || (r_state == S_RDI);
      w_busy     = w_wr_phase || w_rd_phase;
      w_last     = (r_cnt == LAST_ADDR);
      w_exp_full = bist_exp(BIST_MAX_A'(r_cnt), BIST_MAX_W'(r_pat), w_inv);
      w_exp      = w_exp_full[WIDTH-1:0];
      w_mis      = w_rd_phase && (bus.mem_rd != w_exp);
   end

   // Memory-side drive; write data is shown during reads too, and idles at zero.
   always_comb begin
      bus.busy      = w_busy;
      bus.mem_we    = w_wr_phase;
      bus.mem_a     = w_busy ? r_cnt : '0;
      bus.mem_wd    = w_busy ? w_exp : '0;
      bus.done      = r_done;
      bus.pass      = r_pass;
      bus.fail_addr = r_fail_addr;
   end

   // Next-state: accept start when idle/done, walk addresses, abort on mismatch.
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_pat       = r_pat;
      w_done      = r_done;
      w_pass      = r_pass;
      w_fail_addr = r_fail_addr;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_state     = S_WR;
               w_pat       = bus.pattern;
               w_done      = 1'b0;
               w_pass      = 1'b0;
               w_fail_addr = '0;
               w_cnt       = '0;
            end
         end
         S_WR, S_RD, S_WRI, S_RDI: begin
            if (w_mis) begin
               // First mismatch ends the test; later addresses stay untested.
               w_state     = S_DONE;
               w_done      = 1'b1;
               w_pass      = 1'b0;
               w_fail_addr = r_cnt;
               w_cnt       = '0;
            end else if (w_last) begin
               w_cnt = '0;
               case (r_state)
                  S_WR:    w_state = S_RD;
                  S_RD:    w_state = S_WRI;
                  S_WRI:   w_state = S_RDI;
                  default: begin
                     w_state = S_DONE;
                     w_done  = 1'b1;
                     w_pass  = 1'b1;
                  end
               endcase
            end else begin
               w_cnt = r_cnt + ADDR_WIDTH'(1);
            end
         end
         default: begin
            w_state = S_IDLE;
            w_cnt   = '0;
         end
      endcase
   end

   // State register; reset aborts any test in flight immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_pat       <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_addr <= '0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_pat       <= w_pat;
         r_done      <= w_done;
         r_pass      <= w_pass;
         r_fail_addr <= w_fail_addr;
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
// Scoreboard bench for mem_bist with a behavioural 16x8 memory and read-fault injection.
// Latency: checks busy duration, final status and every memory write in order.
// Backpressure: start held high during a run must not cause a second run.
module tb_mem_bist;
   localparam int W = 8;
   localparam int L = 16;

   typedef struct {
      int cyc;
      int ps;
      int fa;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_bist_if #(.WIDTH(W), .LENGTH(L)) bus ();

   mem_bist #(.WIDTH(W), .LENGTH(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_mis = 0;
   int           fault_mode = 0;
   logic [W-1:0] mem [L];
   logic [W-1:0] w_rd;
   logic [11:0]  wr_q [$];
   res_t         res_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Behavioural memory: one-edge write, combinational read.
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_a] <= bus.mem_wd;
   end

   // Read path with stuck-bit faults injected at chosen addresses.
   always_comb begin
      w_rd = mem[bus.mem_a];
      if (fault_mode == 1 && bus.mem_a == 4'd4) w_rd[0] = 1'b1;
      if (fault_mode == 2 && bus.mem_a == 4'd3) w_rd[7] = 1'b0;
   end
   assign bus.mem_rd = w_rd;

   // Every write cycle is popped against the expected write stream.
   always @(negedge clk) begin
      logic [11:0] e;
      if (bus.mem_we) begin
         if (wr_q.size() == 0) begin
            chk("wr_unexpected", 32'(bus.mem_a), 32'hFFFF);
         end else begin
            e = wr_q.pop_front();
            chk("wr_addr", 32'(bus.mem_a), 32'(e[11:8]));
            chk("wr_data", 32'(bus.mem_wd), 32'(e[7:0]));
         end
      end
   end

   task automatic push_writes(input logic [7:0] pat, input bit with_inv);
      logic [7:0] a;
      for (int i = 0; i < L; i++) begin
         a = 8'(i);
         wr_q.push_back({a[3:0], a ^ pat});
      end
      if (with_inv) begin
         for (int i = 0; i < L; i++) begin
            a = 8'(i);
            wr_q.push_back({a[3:0], ~(a ^ pat)});
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},   32'(bus.busy), 0);
      chk({tag, "_done"},   32'(bus.done), 0);
      chk({tag, "_pass"},   32'(bus.pass), 0);
      chk({tag, "_fa"},     32'(bus.fail_addr), 0);
      chk({tag, "_we"},     32'(bus.mem_we), 0);
      chk({tag, "_a"},      32'(bus.mem_a), 0);
      chk({tag, "_wd"},     32'(bus.mem_wd), 0);
   endtask

   task automatic run_test(input logic [7:0] pat, input int fault, input int exp_cyc,
                           input int exp_pass, input int exp_fa,
                           input bit hold_start, input bit chg_pat);
      res_t r;
      int   cyc;
      bit   got;
      fault_mode = fault;
      push_writes(pat, exp_cyc > 2 * L);
      res_q.push_back('{cyc: exp_cyc, ps: exp_pass, fa: exp_fa});
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.pattern = pat;
      @(posedge clk); #1;
      if (!hold_start) bus.start = 1'b0;
      chk("busy_after_start", 32'(bus.busy), 1);
      chk("done_cleared", 32'(bus.done), 0);
      if (chg_pat) bus.pattern = 8'h00;
      cyc = 0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.busy) cyc++;
         if (bus.done) begin
            got = 1'b1;
            break;
         end
      end
      bus.start = 1'b0;
      chk("done_seen", 32'(got), 1);
      r = res_q.pop_front();
      chk("busy_cycles", 32'(cyc), 32'(r.cyc));
      chk("pass", 32'(bus.pass), 32'(r.ps));
      chk("fail_addr", 32'(bus.fail_addr), 32'(r.fa));
      chk("busy_low_at_done", 32'(bus.busy), 0);
      if (hold_start) begin
         @(negedge clk);
         chk("no_restart_busy", 32'(bus.busy), 0);
         chk("no_restart_done", 32'(bus.done), 1);
      end
      chk("wr_q_drained", 32'(wr_q.size()), 0);
      fault_mode = 0;
   endtask

   task automatic reset_mid_rd();
      bit found;
      push_writes(8'h3C, 1'b0);
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.pattern = 8'h3C;
      @(posedge clk); #1;
      bus.start   = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.busy && !bus.mem_we && bus.mem_a == 4'd7) begin
            found = 1'b1;
            break;
         end
      end
      chk("reached_rd7", 32'(found), 1);
      chk("rst_pre_wd", 32'(bus.mem_wd), 32'(8'h07 ^ 8'h3C));
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      chk("wr_q_drained_rst", 32'(wr_q.size()), 0);
      wr_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.pattern = '0;
      for (int i = 0; i < L; i++) mem[i] = 8'h33;
      #2;
      check_reset_outputs("por");
      @(posedge clk); #1;
      rst = 1'b0;

      reset_mid_rd();
      run_test(8'h3C, 0, 64, 1, 0, 1'b0, 1'b0);
      run_test(8'h00, 0, 64, 1, 0, 1'b0, 1'b0);
      run_test(8'h00, 1, 21, 0, 4, 1'b0, 1'b0);
      run_test(8'h00, 2, 52, 0, 3, 1'b0, 1'b0);
      run_test(8'h5A, 0, 64, 1, 0, 1'b1, 1'b0);
      chk("done_before_restart", 32'(bus.done), 1);
      run_test(8'h5A, 0, 64, 1, 0, 1'b0, 1'b0);
      run_test(8'hA5, 0, 64, 1, 0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
